// File: rtl/gpu_cmd_encoder.sv
// rtl/gpu_cmd_encoder.sv - packs host draw/alpha commands into 82-bit words
// and buffers them in a first-word-fall-through FIFO for the GPU controller.
module gpu_cmd_encoder #(
  parameter int         DEPTH = 8,
  parameter logic [7:0] MAX_X = 8'd159,
  parameter logic [7:0] MAX_Y = 8'd119
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic                     inst_type,
  input  logic                     vertice_num,
  input  logic                     fill_type,
  input  logic                     layer_num,
  input  logic [7:0]               x0,
  input  logic [7:0]               y0,
  input  logic [7:0]               x1,
  input  logic [7:0]               y1,
  input  logic [7:0]               x2,
  input  logic [7:0]               y2,
  input  logic [23:0]              color_code,
  input  logic [1:0]               texture_code,
  input  logic [3:0]               alpha_val,
  output logic [81:0]              fifo_data,
  output logic                     fifo_empty,
  input  logic                     fifo_read,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     cmd_err,
  output logic [7:0]               err_cnt
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [81:0]   mem_q [DEPTH];
  logic [AW-1:0] head_q, head_d;
  logic [AW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          cmd_err_q, cmd_err_d;
  logic [7:0]    err_cnt_q, err_cnt_d;

  logic          in_bounds;
  logic          accept;
  logic          push;
  logic          reject;
  logic          pop;
  logic [47:0]   coords;
  logic [81:0]   word;

  always_comb begin
    in_bounds = (x0 <= MAX_X) && (x1 <= MAX_X) && (x2 <= MAX_X) &&
                (y0 <= MAX_Y) && (y1 <= MAX_Y) && (y2 <= MAX_Y);
    // Alpha-blend words carry no geometry, so coordinates are zeroed.
    coords    = inst_type ? 48'd0 : {y2, x2, y1, x1, y0, x0};
    word      = {alpha_val, texture_code, color_code, fill_type, layer_num,
                 coords, vertice_num, inst_type};

    accept = cmd_valid && cmd_ready;
    push   = accept && (inst_type || in_bounds);
    reject = accept && !inst_type && !in_bounds;
    pop    = fifo_read && (count_q != '0);

    head_d  = pop  ? head_q + AW'(1) : head_q;
    tail_d  = push ? tail_q + AW'(1) : tail_q;
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    cmd_err_d = reject;
    err_cnt_d = (reject && (err_cnt_q != 8'hFF)) ? err_cnt_q + 8'd1 : err_cnt_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      cmd_err_q <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      head_q    <= head_d;
      tail_q    <= tail_d;
      count_q   <= count_d;
      cmd_err_q <= cmd_err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      mem_q[tail_q] <= word;
    end
  end

  assign cmd_ready  = (count_q < FULL_CNT);
  assign fifo_data  = mem_q[head_q];
  assign fifo_empty = (count_q == '0);
  assign count      = count_q;
  assign cmd_err    = cmd_err_q;
  assign err_cnt    = err_cnt_q;

endmodule

// File: doc/gpu_cmd_encoder.md
# gpu_cmd_encoder

Host-side producer for the GPU instruction stream. It accepts draw and alpha-blend commands as discrete fields over a valid/ready handshake and checks coordinates against the frame bounds. Legal commands are packed into the 82-bit instruction word and buffered in a first-word-fall-through FIFO. The FIFO drives the `fifo_data` / `fifo_empty` inputs of `overall` and is popped by the GPU controller.

## Interface
- `DEPTH`, 8: FIFO entries; power of two, ≥2.
- `MAX_X`, 8'd159: largest legal x coordinate.
- `MAX_Y`, 8'd119: largest legal y coordinate.
- `clk`  in  1  system clock; all state on rising edge.
- `rst`  in  1  reset; synchronous, active-high.
- `cmd_valid`  in  1  host command present.
- `cmd_ready`  out  1  encoder can take a command this cycle.
- `inst_type`  in  1  0 = draw (line/fill), 1 = alpha blend.
- `vertice_num`, `fill_type`, `layer_num`  in  1 each  passed through.
- `x0,y0,x1,y1,x2,y2`  in  8 each  vertex coordinates.
- `color_code`  in  24  RGB colour.
- `texture_code`  in  2  texture select.
- `alpha_val`  in  4  blend factor.
- `fifo_data`  out  82  head instruction word.
- `fifo_empty`  out  1  no instruction available.
- `fifo_read`  in  1  GPU pop strobe; consumes the head word.
- `count`  out  $clog2(DEPTH)+1  number of stored entries.
- `cmd_err`  out  1  one-cycle pulse: a command was rejected.
- `err_cnt`  out  8  rejected-command counter; saturates at 255.

## Operation
- **Packing**, LSB first:
  - [0] `inst_type`, [1] `vertice_num`
  - [9:2] `x0`, [17:10] `y0`, [25:18] `x1`, [33:26] `y1`, [41:34] `x2`, [49:42] `y2`
  - [50] `layer_num`, [51] `fill_type`
  - [75:52] `color_code`, [77:76] `texture_code`, [81:78] `alpha_val`
- **Alpha commands** (`inst_type`=1): all six coordinates are forced to 0 in the packed word. They are never bounds-checked.
- **Draw commands** (`inst_type`=0): rejected if any `x*` > `MAX_X` or any `y*` > `MAX_Y`.
- **Handshake**: a command is accepted when `cmd_valid && cmd_ready`.
  - A legal accepted command is written at the tail.
  - A rejected accepted command is dropped. `cmd_err`=1 next cycle and `err_cnt` increments, saturating.
- **Readiness**: `cmd_ready` = (`count` < `DEPTH`). It is purely state-based, with no same-cycle pop bypass. When full, even illegal commands stall.
- **FIFO**: circular buffer, with head pointer, tail pointer and `count`.
  - Pointers wrap modulo `DEPTH`.
  - `fifo_data` = mem[head], combinational from registers.
  - `fifo_empty` = (`count` == 0).
- **Pop**: `fifo_read` with `count`>0 advances head. `fifo_read` while empty is ignored: no pointer change, no error.
- **Simultaneous** legal push and valid pop: both pointers advance and `count` is unchanged. A rejected push plus a pop behaves as a pop only.
- **Reset**: clears pointers, `count`, `cmd_err` and `err_cnt`. Memory contents are don't-care. Reset mid-stream discards all stored entries. A command presented in the reset cycle is not accepted.
- **Datapath**: no arithmetic beyond the pointer and counter increments. The bounds compare is unsigned 8-bit.

## Timing
- Reset values:
  - `cmd_ready`=1, `fifo_empty`=1, `count`=0, `cmd_err`=0, `err_cnt`=0.
  - `fifo_data` = mem[0], undefined content.
- Push latency: a command accepted at edge N is visible on `fifo_data` with `fifo_empty`=0 after edge N, i.e. during cycle N+1.
- Pop: `fifo_read` sampled at edge N. The next entry appears on `fifo_data` after edge N. If that pop emptied the FIFO, `fifo_empty`=1 after edge N.
- `cmd_ready` deasserts the cycle after the push that fills the FIFO. It reasserts the cycle after the first pop from full.
- `cmd_err` is high exactly one cycle per rejection. Back-to-back rejections keep it high on consecutive cycles.
- The GPU may hold `fifo_read` high across consecutive cycles, popping one entry per cycle.

## Test plan
- **Reset, then packing**: push draw x0=10, y0=10, x1=10, y1=60, x2=50, y2=10, `color_code`=FFEEDD, `vertice_num`=1, all other fields 0.
  - Next cycle: `fifo_empty`=0 and `fifo_data` equals the exact concatenation above.
  - Pop: `fifo_empty`=1.
- **Alpha force-zero**: push alpha with `alpha_val`=7, `layer_num`=1 and nonzero coordinates.
  - `fifo_data`[49:2]=0, [81:78]=7, [0]=1.
  - `cmd_err` stays 0.
- **Bounds**: push draw with x2=160 (`MAX_X`=159).
  - `cmd_ready`=1 and the command is dropped: `count` stays 0.
  - `cmd_err` pulses for 1 cycle and `err_cnt`=1.
  - 300 further rejects: `err_cnt`=255.
- **Full and wrap**: push 8 legal commands with distinct colours.
  - `count`=8, `cmd_ready`=0, and a 9th `cmd_valid` is held.
  - Pop once: `cmd_ready`=1, and the 9th is accepted into the wrapped slot.
  - Drain: the 9 colours appear in order.
- **Simultaneous**: with `count`=3, push legal and pop in the same cycle.
  - `count`=3 and the head advances.
  - `fifo_read` while empty: no change.
- **Reset mid-operation**: assert `rst` with `count`=5 and `cmd_valid`=1.
  - Next cycle: `count`=0, `fifo_empty`=1, `err_cnt`=0, and the command is not stored.
